// File: rtl/wb_io_bridge_pkg.sv
// Shared definitions for the Wishbone IO bridge: register offsets,
// MODE bit layout, address window mask and byte-lane helpers.
package wb_io_bridge_pkg;

   localparam logic [7:0] REG_OUT      = 8'h00;
   localparam logic [7:0] REG_OEB      = 8'h04;
   localparam logic [7:0] REG_IN       = 8'h08;
   localparam logic [7:0] REG_IRQ_EN   = 8'h0C;
   localparam logic [7:0] REG_STATUS   = 8'h10;
   localparam logic [7:0] REG_EDGE_SEL = 8'h14;
   localparam logic [7:0] REG_MODE     = 8'h18;

   localparam int MODE_LA_BIT = 0;

   // Upper 24 address bits select the 256-byte window
   localparam logic [31:0] WIN_MASK = 32'hFFFF_FF00;

   // Expand the four byte selects into a 32-bit bit mask
   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   // Replace only the selected byte lanes of old_val with new_val
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] m;
      m = byte_mask(sel);
      return (old_val & ~m) | (new_val & m);
   endfunction

endpackage

// File: rtl/wb_io_bridge_edge.sv
// Per-channel input conditioning: two-flop synchroniser, one history
// flop, and the rising/falling edge comparison selected per channel.
module io_edge_detect #(
   parameter int NCH = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] pin,
   input  logic [NCH-1:0] edge_sel,
   output logic [NCH-1:0] sync,
   output logic [NCH-1:0] edge_pulse
);

   logic [NCH-1:0] meta_r;
   logic [NCH-1:0] sync_r;
   logic [NCH-1:0] hist_r;

   // Synchronise asynchronous pad inputs and keep one cycle of history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= {NCH{1'b0}};
         sync_r <= {NCH{1'b0}};
         hist_r <= {NCH{1'b0}};
      end else begin
         meta_r <= pin;
         sync_r <= meta_r;
         hist_r <= sync_r;
      end
   end

   assign sync = sync_r;
   // A change whose new level differs from edge_sel: rising when sel=0, falling when sel=1.
   // edge_sel is not part of the history, so reprogramming it never fakes an edge.
   assign edge_pulse = (sync_r ^ hist_r) & (sync_r ^ edge_sel);

endmodule

// File: rtl/wb_io_bridge.sv
// Wishbone-controlled IO bridge: programmable pad outputs/enables,
// synchronised inputs with edge interrupts, and per-channel LA override.
module wb_io_bridge
   import wb_io_bridge_pkg::*;
#(
   parameter int          NCH       = 16,
   parameter int          IRQ_LINES = 3,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic [31:0]          wbs_dat_o,
   output logic                 wbs_ack_o,
   input  logic [NCH-1:0]       io_in,
   output logic [NCH-1:0]       io_out,
   output logic [NCH-1:0]       io_oeb,
   input  logic [2*NCH-1:0]     la_data_in,
   input  logic [NCH-1:0]       la_oenb,
   output logic [NCH-1:0]       la_data_out,
   output logic [IRQ_LINES-1:0] user_irq
);

   logic [NCH-1:0]       out_r, oeb_r, irq_en_r, status_r, edge_sel_r;
   logic                 mode_r;
   logic                 ack_r;
   logic [31:0]          dat_r;
   logic [IRQ_LINES-1:0] irq_r;

   logic [NCH-1:0]       sync_s, edge_s, clr_s;
   logic                 hit_s, wr_s;
   logic [7:0]           off_s;
   logic [31:0]          out_p_s, oeb_p_s, en_p_s, st_p_s, es_p_s, in_p_s, mode_p_s;
   logic [31:0]          out_m_s, oeb_m_s, en_m_s, es_m_s, mode_m_s, clr_m_s;
   logic [31:0]          rdata_s;
   logic [IRQ_LINES-1:0] irq_s;
   logic                 unused_bits_s;

   io_edge_detect #(.NCH(NCH)) u_edge (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .pin        (io_in),
      .edge_sel   (edge_sel_r),
      .sync       (sync_s),
      .edge_pulse (edge_s)
   );

   // The !ack term forces a dead cycle between back-to-back transfers
   assign hit_s = wbs_cyc_i & wbs_stb_i & ~ack_r &
                  ((wbs_adr_i & WIN_MASK) == (BASE_ADDR & WIN_MASK));
   assign wr_s  = hit_s & wbs_we_i;
   assign off_s = wbs_adr_i[7:0];

   // Zero-extend registers to bus width and form byte-merged write values
   always_comb begin
      out_p_s  = 32'h0;
      oeb_p_s  = 32'h0;
      en_p_s   = 32'h0;
      st_p_s   = 32'h0;
      es_p_s   = 32'h0;
      in_p_s   = 32'h0;
      mode_p_s = 32'h0;
      out_p_s[NCH-1:0]      = out_r;
      oeb_p_s[NCH-1:0]      = oeb_r;
      en_p_s[NCH-1:0]       = irq_en_r;
      st_p_s[NCH-1:0]       = status_r;
      es_p_s[NCH-1:0]       = edge_sel_r;
      in_p_s[NCH-1:0]       = sync_s;
      mode_p_s[MODE_LA_BIT] = mode_r;
      out_m_s  = merge_bytes(out_p_s, wbs_dat_i, wbs_sel_i);
      oeb_m_s  = merge_bytes(oeb_p_s, wbs_dat_i, wbs_sel_i);
      en_m_s   = merge_bytes(en_p_s, wbs_dat_i, wbs_sel_i);
      es_m_s   = merge_bytes(es_p_s, wbs_dat_i, wbs_sel_i);
      mode_m_s = merge_bytes(mode_p_s, wbs_dat_i, wbs_sel_i);
      if (wr_s && (off_s == REG_STATUS)) begin
         clr_m_s = wbs_dat_i & byte_mask(wbs_sel_i);
      end else begin
         clr_m_s = 32'h0;
      end
      clr_s = clr_m_s[NCH-1:0];
   end

   // Bits above NCH are discarded on write
   assign unused_bits_s = ^{out_m_s, oeb_m_s, en_m_s, es_m_s, mode_m_s, clr_m_s};

   // Read data selection by word offset
   always_comb begin
      case (off_s)
         REG_OUT:      rdata_s = out_p_s;
         REG_OEB:      rdata_s = oeb_p_s;
         REG_IN:       rdata_s = in_p_s;
         REG_IRQ_EN:   rdata_s = en_p_s;
         REG_STATUS:   rdata_s = st_p_s;
         REG_EDGE_SEL: rdata_s = es_p_s;
         REG_MODE:     rdata_s = mode_p_s;
         default:      rdata_s = 32'h0;
      endcase
   end

   // Control registers; STATUS sets on edges, with set taking priority over W1C
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         out_r      <= {NCH{1'b0}};
         oeb_r      <= {NCH{1'b1}};
         irq_en_r   <= {NCH{1'b0}};
         status_r   <= {NCH{1'b0}};
         edge_sel_r <= {NCH{1'b0}};
         mode_r     <= 1'b0;
      end else begin
         if (wr_s) begin
            case (off_s)
               REG_OUT:      out_r      <= out_m_s[NCH-1:0];
               REG_OEB:      oeb_r      <= oeb_m_s[NCH-1:0];
               REG_IRQ_EN:   irq_en_r   <= en_m_s[NCH-1:0];
               REG_EDGE_SEL: edge_sel_r <= es_m_s[NCH-1:0];
               REG_MODE:     mode_r     <= mode_m_s[MODE_LA_BIT];
               default:      mode_r     <= mode_r;
            endcase
         end
         status_r <= (status_r & ~clr_s) | edge_s;
      end
   end

   // Single-cycle ack with registered read data, zero outside ack
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_r <= 1'b0;
         dat_r <= 32'h0;
      end else if (hit_s) begin
         ack_r <= 1'b1;
         dat_r <= rdata_s;
      end else begin
         ack_r <= 1'b0;
         dat_r <= 32'h0;
      end
   end

   // Fold enabled status bits onto interrupt lines by channel index modulo IRQ_LINES
   always_comb begin
      irq_s = {IRQ_LINES{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         irq_s[i % IRQ_LINES] = irq_s[i % IRQ_LINES] | (status_r[i] & irq_en_r[i]);
      end
   end

   // Register the interrupt lines
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         irq_r <= {IRQ_LINES{1'b0}};
      end else begin
         irq_r <= irq_s;
      end
   end

   // Pad mux: LA takes a channel when override mode is on and its oenb is low
   always_comb begin
      io_out = out_r;
      io_oeb = oeb_r;
      for (int i = 0; i < NCH; i++) begin
         if (mode_r && !la_oenb[i]) begin
            io_out[i] = la_data_in[i];
            io_oeb[i] = la_data_in[NCH+i];
         end else begin
            io_out[i] = out_r[i];
            io_oeb[i] = oeb_r[i];
         end
      end
   end

   assign la_data_out = sync_s;
   assign wbs_dat_o   = dat_r;
   assign wbs_ack_o   = ack_r;
   assign user_irq    = irq_r;

endmodule

// File: tb/tb_wb_io_bridge.sv
// Self-checking bench for wb_io_bridge (NCH=16, IRQ_LINES=3).
module tb_wb_io_bridge;

   localparam int          NCH       = 16;
   localparam int          IRQ_LINES = 3;
   localparam logic [31:0] BASE      = 32'h3000_0000;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]           sel = 4'h0;
   logic [31:0]          adr = 32'h0, wdat = 32'h0;
   logic [31:0]          rdat;
   logic                 ack;
   logic [NCH-1:0]       io_in = 16'h0;
   logic [NCH-1:0]       io_out, io_oeb, la_data_out;
   logic [2*NCH-1:0]     la_data_in = 32'h0;
   logic [NCH-1:0]       la_oenb = 16'hFFFF;
   logic [IRQ_LINES-1:0] user_irq;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   wb_io_bridge #(.NCH(NCH), .IRQ_LINES(IRQ_LINES), .BASE_ADDR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
      .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
      .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
      .user_irq(user_irq)
   );

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one transfer, wait (bounded) for ack, then check ack fell after one cycle
   task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input string name, output logic got,
                          output logic [31:0] data);
      got  = 1'b0;
      data = 32'h0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            got  = 1'b1;
            data = rdat;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL %s_ack: got no ack, required ack within 8 cycles", name);
      end else begin
         @(posedge clk); #1;
         vectors++;
         if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ack_width: ack=%b, required 0 one cycle after ack", name, ack);
         end
      end
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                           input string name);
      logic        got;
      logic [31:0] data;
      wb_xfer(BASE + {24'h0, off}, 1'b1, d, s, name, got, data);
   endtask

   task automatic wb_read(input logic [7:0] off, input logic [31:0] expv, input string name);
      logic        got;
      logic [31:0] data;
      logic [31:0] e;
      exp_q.push_back(expv);
      wb_xfer(BASE + {24'h0, off}, 1'b0, 32'h0, 4'hF, name, got, data);
      e = exp_q.pop_front();
      if (got) begin
         vectors++;
         if (data !== e) begin
            miscompares++;
            $display("FAIL %s: read %h, required %h", name, data, e);
         end
      end
   endtask

   task automatic check_pins(input string name, input logic [15:0] eo, input logic [15:0] eb);
      vectors++;
      if (io_out !== eo || io_oeb !== eb) begin
         miscompares++;
         $display("FAIL %s: io_out=%h io_oeb=%h, required io_out=%h io_oeb=%h",
                  name, io_out, io_oeb, eo, eb);
      end
   endtask

   task automatic check_irq(input string name, input logic [2:0] e);
      vectors++;
      if (user_irq !== e) begin
         miscompares++;
         $display("FAIL %s: user_irq=%b, required %b", name, user_irq, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_pins("reset_pins", 16'h0000, 16'hFFFF);
      check_irq("reset_irq", 3'b000);
      vectors++;
      if (ack !== 1'b0 || rdat !== 32'h0 || la_data_out !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_bus: ack=%b dat=%h la_out=%h, required 0/0/0", ack, rdat, la_data_out);
      end
      wb_read(8'h00, 32'h0000_0000, "rst_out");
      wb_read(8'h04, 32'h0000_FFFF, "rst_oeb");
      wb_read(8'h08, 32'h0000_0000, "rst_in");
      wb_read(8'h0C, 32'h0000_0000, "rst_irq_en");
      wb_read(8'h10, 32'h0000_0000, "rst_status");
      wb_read(8'h14, 32'h0000_0000, "rst_edge_sel");
      wb_read(8'h18, 32'h0000_0000, "rst_mode");
   endtask

   task automatic test_out_oeb();
      wb_write(8'h00, 32'h0000_00A5, 4'b0001, "wr_out");
      wb_write(8'h04, 32'h0000_0000, 4'b1111, "wr_oeb");
      check_pins("out_oeb_pins", 16'h00A5, 16'h0000);
      wb_write(8'h00, 32'h0000_FFFF, 4'b0010, "wr_out_b1");
      wb_read(8'h00, 32'h0000_FFA5, "out_byte1");
      check_pins("out_byte1_pins", 16'hFFA5, 16'h0000);
      wb_write(8'h00, 32'hFFFF_FFFF, 4'b1100, "wr_out_hi");
      wb_read(8'h00, 32'h0000_FFA5, "out_upper_ignored");
      wb_write(8'h1C, 32'hFFFF_FFFF, 4'b1111, "wr_unmapped");
      wb_read(8'h1C, 32'h0000_0000, "unmapped_read");
   endtask

   task automatic test_rise();
      wb_write(8'h0C, 32'h0000_0001, 4'hF, "wr_irq_en");
      wb_write(8'h14, 32'h0000_0000, 4'hF, "wr_edge_sel");
      @(negedge clk);
      io_in[0] = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (la_data_out[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL sync_lat1: la_data_out[0]=%b, required 0", la_data_out[0]);
      end
      @(posedge clk); #1;
      vectors++;
      if (la_data_out[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL sync_lat2: la_data_out[0]=%b, required 1", la_data_out[0]);
      end
      @(posedge clk); #1;
      check_irq("irq_early", 3'b000);
      @(posedge clk); #1;
      check_irq("irq_rise", 3'b001);
      wb_read(8'h10, 32'h0000_0001, "status_rise");
      wb_write(8'h10, 32'h0000_0001, 4'hF, "w1c_0");
      check_irq("irq_cleared", 3'b000);
      wb_read(8'h10, 32'h0000_0000, "status_cleared");
   endtask

   task automatic test_fall();
      wb_write(8'h14, 32'h0000_0010, 4'hF, "wr_edge_sel4");
      wb_write(8'h0C, 32'h0000_0011, 4'hF, "wr_irq_en4");
      @(negedge clk);
      io_in[4] = 1'b1;
      wait_cycles(5);
      wb_read(8'h10, 32'h0000_0000, "fall_no_rise");
      check_irq("fall_no_rise_irq", 3'b000);
      @(negedge clk);
      io_in[4] = 1'b0;
      wait_cycles(5);
      wb_read(8'h10, 32'h0000_0010, "fall_status");
      check_irq("fall_irq", 3'b010);
      wb_write(8'h10, 32'h0000_0000, 4'hF, "w1c_zero");
      wb_read(8'h10, 32'h0000_0010, "w1c_zero_noop");
      wb_write(8'h10, 32'h0000_0010, 4'hF, "w1c_4");
      wb_read(8'h10, 32'h0000_0000, "fall_cleared");
      wb_write(8'h14, 32'h0000_0011, 4'hF, "edge_sel_flip");
      wait_cycles(4);
      wb_read(8'h10, 32'h0000_0000, "sel_change_no_edge");
      wb_write(8'h14, 32'h0000_0000, 4'hF, "edge_sel_restore");
   endtask

   task automatic test_w1c_race();
      @(negedge clk); io_in[0] = 1'b0;
      wait_cycles(5);
      @(negedge clk); io_in[0] = 1'b1;
      wait_cycles(5);
      wb_read(8'h10, 32'h0000_0001, "race_pre");
      @(negedge clk); io_in[0] = 1'b0;
      wait_cycles(5);
      // Rising edge before posedge k; its STATUS set lands on posedge k+2 with the W1C
      @(negedge clk); io_in[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      wb_write(8'h10, 32'h0000_0001, 4'hF, "race_w1c");
      wb_read(8'h10, 32'h0000_0001, "race_set_wins");
      check_irq("race_irq", 3'b001);
      wb_write(8'h10, 32'h0000_0001, 4'hF, "race_clear");
      wb_read(8'h10, 32'h0000_0000, "race_cleared");
   endtask

   task automatic test_la();
      wb_write(8'h00, 32'h0000_00A4, 4'hF, "la_out");
      wb_write(8'h04, 32'h0000_0F00, 4'hF, "la_oeb");
      wb_write(8'h18, 32'h0000_0001, 4'hF, "la_mode");
      @(negedge clk);
      la_oenb    = 16'hFFFE;
      la_data_in = {16'h0000, 16'h0001};
      #1 check_pins("la_ch0_out", 16'h00A5, 16'h0F00);
      la_data_in = {16'h0001, 16'h0000};
      #1 check_pins("la_ch0_oeb", 16'h00A4, 16'h0F01);
      wb_read(8'h18, 32'h0000_0001, "mode_read");
      wb_write(8'h18, 32'h0000_0000, 4'hF, "la_mode_off");
      check_pins("la_mode_off_pins", 16'h00A4, 16'h0F00);
   endtask

   task automatic test_in_window();
      logic        got;
      logic [31:0] data;
      @(negedge clk); io_in = 16'hC3C1;
      wait_cycles(5);
      wb_read(8'h08, 32'h0000_C3C1, "in_reg");
      vectors++;
      if (la_data_out !== 16'hC3C1) begin
         miscompares++;
         $display("FAIL la_mirror: la_data_out=%h, required C3C1", la_data_out);
      end
      got = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; wdat = 32'hFFFF_FFFF; sel = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) got = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      vectors++;
      if (got) begin
         miscompares++;
         $display("FAIL out_of_window: ack seen, required no ack");
      end
      wb_read(8'h00, 32'h0000_00A4, "out_of_window_nowrite");
      data = 32'h0;
      wb_xfer(BASE + 32'h0000_0004, 1'b0, 32'h0, 4'hF, "reread_oeb", got, data);
      vectors++;
      if (data !== 32'h0000_0F00) begin
         miscompares++;
         $display("FAIL reread_oeb: read %h, required 00000F00", data);
      end
   endtask

   task automatic test_reset_mid();
      logic got;
      got = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) got = 1'b1;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL mid_reset_ack: got no ack, required ack");
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (ack !== 1'b0 || rdat !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset_drop: ack=%b dat=%h, required 0/0", ack, rdat);
      end
      check_pins("mid_reset_pins", 16'h0000, 16'hFFFF);
      cyc = 1'b0; stb = 1'b0;
      io_in = 16'h0;
      @(negedge clk); rst = 1'b0;
      wb_read(8'h04, 32'h0000_FFFF, "post_reset_oeb");
   endtask

   initial begin
      test_reset();
      test_out_oeb();
      test_rise();
      test_fall();
      test_w1c_race();
      test_la();
      test_in_window();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
